seg_display_arbiter: RTL

//  Shares the 4-digit multiplexed 7-segment display between NREQ requesters (e.g. counter, key status, debug).

---
 rtl/seg_pkg.sv | 49 ++++
 rtl/seg_scan.sv | 101 ++++++++++
 rtl/seg_display_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : seg_pkg                                                         |
// | Purpose  : Shared types and constants for the 7-segment display arbiter:   |
// |            hex-to-GFEDCBA font, digit-select idle value, arbiter states.    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  // Number of multiplexed digits on the display
  localparam int NUM_DIGITS = 4;

  // Digit-select value with every digit dark (cathodes are active-low)
  localparam logic [3:0] SCATHOD_OFF = 4'b1111;

  // Arbiter states
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Hex nibble to segment pattern, bit order GFEDCBA, active-high
  function automatic logic [6:0] seg_font(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan.sv
// +----------------------------------------------------------------------------+
// | Module   : seg_scan                                                        |
// | Purpose  : Digit scan scheduler. Free-running slot/digit counters, value    |
// |            snapshot at slot start, per-slot blanking gap, font lookup.      |
// |            Optional macro LEAD_ZERO_BLANK_EN blanks leading-zero digits.    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 65536,
  parameter int BLANK_CYC = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  // Value and validity of the owner that holds the display after this edge
  input  logic [15:0] i_value,
  input  logic        i_valid,
  // Owner is changing on this edge
  input  logic        i_change,
  output logic [3:0]  o_scathod,
  output logic [6:0]  o_ssegment
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] r_slot;
  logic [1:0]    r_digit;
  logic [15:0]   r_snap;
  logic          r_ok;

  logic          w_start;
  logic          w_wrap;
  logic          w_ok;
  logic [15:0]   w_snap;
  logic [3:0]    w_nib;
  logic          w_lead_zero;
  logic          w_in_blank;

  // Slot bookkeeping: the snapshot and owner-stable flag are (re)armed on the
  // first cycle of each slot and the flag is cleared by any owner loss/change.
  always_comb begin
    w_start    = (r_slot == '0);
    w_wrap     = (r_slot == SW'(SCAN_DIV - 1));
    w_ok       = w_start ? i_valid : (r_ok & i_valid & ~i_change);
    w_snap     = w_start ? i_value : r_snap;
    w_in_blank = (r_slot < SW'(BLANK_CYC));
    case (r_digit)
      2'd0:    w_nib = w_snap[3:0];
      2'd1:    w_nib = w_snap[7:4];
      2'd2:    w_nib = w_snap[11:8];
      default: w_nib = w_snap[15:12];
    endcase
`ifdef LEAD_ZERO_BLANK_EN
    case (r_digit)
      2'd0:    w_lead_zero = 1'b0;
      2'd1:    w_lead_zero = (w_snap[15:4] == '0);
      2'd2:    w_lead_zero = (w_snap[15:8] == '0);
      default: w_lead_zero = (w_snap[15:12] == '0);
    endcase
`else
    w_lead_zero = 1'b0;
`endif
  end

  // Free-running slot counter; digit index advances at every slot wrap
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_slot  <= '0;
      r_digit <= '0;
      r_snap  <= '0;
      r_ok    <= 1'b0;
    end else begin
      r_slot <= w_wrap ? '0 : r_slot + 1'b1;
      if (w_wrap) begin
        r_digit <= r_digit + 1'b1;
      end
      r_snap <= w_snap;
      r_ok   <= w_ok;
    end
  end

  // Registered pin drive; dark during the blanking gap or with no stable owner
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      o_scathod  <= SCATHOD_OFF;
      o_ssegment <= '0;
    end else if (!w_ok || w_in_blank || w_lead_zero) begin
      o_scathod  <= SCATHOD_OFF;
      o_ssegment <= '0;
    end else begin
      o_scathod  <= ~(4'b0001 << r_digit);
      o_ssegment <= seg_font(w_nib);
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : seg_display_arbiter                                             |
// | Purpose  : Round-robin arbiter with minimum dwell sharing one 4-digit       |
// |            multiplexed 7-segment display among NREQ requesters.             |
// |            Optional macro LEAD_ZERO_BLANK_EN (in seg_scan) blanks leading   |
// |            zero digits.                                                     |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int SCAN_DIV  = 65536,
  parameter int BLANK_CYC = 256,
  parameter int DWELL     = 50_000_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data,
  output logic [NREQ-1:0]      gnt,
  output logic [3:0]           scathod,
  output logic [6:0]           ssegment
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [DW-1:0]   r_dwell;

  logic [IW-1:0]   w_base;
  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic [NREQ-1:0] w_pick_oh;
  logic            w_release;
  logic            w_switch;
  logic            w_start;
  logic            w_nxt_valid;
  logic            w_nxt_change;
  logic [IW-1:0]   w_nxt_owner;
  logic [15:0]     w_value;

  // Round-robin search: from IDLE start after the pointer (pointer itself is
  // last in line); in HOLD look only at requesters other than the owner.
  always_comb begin
    int idx;
    w_base  = (r_state == IDLE) ? r_ptr : r_owner;
    w_pick  = w_base;
    w_found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(w_base) + i) % NREQ;
      if (!w_found && req[idx] && !(r_state == HOLD && i == NREQ)) begin
        w_found = 1'b1;
        w_pick  = IW'(idx);
      end
    end
    w_pick_oh         = '0;
    w_pick_oh[w_pick] = 1'b1;
  end

  // Transition decode; release outranks a dwell-expiry switch
  always_comb begin
    w_release    = (r_state == HOLD) && !req[r_owner];
    w_switch     = (r_state == HOLD) && !w_release && (r_dwell == '0) && w_found;
    w_start      = (r_state == IDLE) && w_found;
    w_nxt_valid  = w_start || ((r_state == HOLD) && !w_release);
    w_nxt_change = w_start || w_switch;
    w_nxt_owner  = (w_start || w_switch) ? w_pick : r_owner;
  end

  // Value of the owner that will hold the display after this edge
  always_comb begin
    w_value = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_nxt_owner == IW'(i)) begin
        w_value = data[16*i +: 16];
      end
    end
  end

  // Arbiter FSM with registered one-hot grant, RR pointer and dwell counter
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= IW'(NREQ - 1);
      r_dwell <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= HOLD;
            r_gnt   <= w_pick_oh;
            r_owner <= w_pick;
            r_dwell <= DW'(DWELL - 1);
          end
        end
        HOLD: begin
          if (w_release) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= r_owner;
          end else if (w_switch) begin
            r_gnt   <= w_pick_oh;
            r_owner <= w_pick;
            r_ptr   <= r_owner;
            r_dwell <= DW'(DWELL - 1);
          end else if (r_dwell != '0) begin
            r_dwell <= r_dwell - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt = r_gnt;

  seg_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_value    (w_value),
    .i_valid    (w_nxt_valid),
    .i_change   (w_nxt_change),
    .o_scathod  (scathod),
    .o_ssegment (ssegment)
  );

endmodule

`default_nettype wire
